// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_reg
//  Purpose  : EX/MEM pipeline register of the five-stage MIPS pipeline.
//             Captures the Execute-stage ALU result, zero flag, store data,
//             branch target, destination register and downstream control
//             bits. Supports stall (hold) and flush (bubble insertion).
//             Branch-resolution, forwarding and load-use outputs are decoded
//             only from registered state.
//  Ports    : clk, rst_n (async active-low), stall, flush
//             ex_*  : Execute-stage inputs (valid, data, control)
//             mem_* : registered copies presented to the Memory stage
//             pc_src, fwd_en, fwd_reg, fwd_data, load_pending : decoded
//             stat_stall_cnt, stat_bubble_cnt : only with EX_MEM_STATS_EN
//  Options  : `define EX_MEM_STATS_EN adds saturating stall/bubble counters
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic [REG_W-1:0]  ex_write_reg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_branch,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [DATA_W-1:0] mem_branch_target,
    output logic              mem_zero,
    output logic [REG_W-1:0]  mem_write_reg,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_mem_to_reg,
    output logic              mem_branch,
    output logic              pc_src,
    output logic              fwd_en,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_pending
`ifdef EX_MEM_STATS_EN
    ,
    output logic [31:0]       stat_stall_cnt,
    output logic [31:0]       stat_bubble_cnt
`endif
);

    logic              r_valid_q,  w_valid_d;
    logic [DATA_W-1:0] r_result_q, w_result_d;
    logic [DATA_W-1:0] r_sdata_q,  w_sdata_d;
    logic [DATA_W-1:0] r_target_q, w_target_d;
    logic              r_zero_q,   w_zero_d;
    logic [REG_W-1:0]  r_wreg_q,   w_wreg_d;
    logic              r_rw_q,     w_rw_d;
    logic              r_mr_q,     w_mr_d;
    logic              r_mw_q,     w_mw_d;
    logic              r_m2r_q,    w_m2r_d;
    logic              r_br_q,     w_br_d;

    // Next-state selection: flush beats stall beats load.
    always_comb begin
        w_valid_d  = r_valid_q;
        w_result_d = r_result_q;
        w_sdata_d  = r_sdata_q;
        w_target_d = r_target_q;
        w_zero_d   = r_zero_q;
        w_wreg_d   = r_wreg_q;
        w_rw_d     = r_rw_q;
        w_mr_d     = r_mr_q;
        w_mw_d     = r_mw_q;
        w_m2r_d    = r_m2r_q;
        w_br_d     = r_br_q;
        if (flush) begin
            w_valid_d  = 1'b0;
            w_result_d = '0;
            w_sdata_d  = '0;
            w_target_d = '0;
            w_zero_d   = 1'b0;
            w_wreg_d   = '0;
            w_rw_d     = 1'b0;
            w_mr_d     = 1'b0;
            w_mw_d     = 1'b0;
            w_m2r_d    = 1'b0;
            w_br_d     = 1'b0;
        end else if (!stall) begin
            w_valid_d  = ex_valid;
            w_result_d = ex_result;
            w_sdata_d  = ex_store_data;
            w_target_d = ex_branch_target;
            w_zero_d   = ex_zero;
            w_wreg_d   = ex_write_reg;
            // Control bits of a non-instruction must never have side effects;
            // writes to $zero are dropped here so forwarding never sees them.
            w_rw_d     = ex_valid & ex_reg_write & (ex_write_reg != '0);
            w_mr_d     = ex_valid & ex_mem_read;
            w_mw_d     = ex_valid & ex_mem_write;
            w_m2r_d    = ex_valid & ex_mem_to_reg;
            w_br_d     = ex_valid & ex_branch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q  <= 1'b0;
            r_result_q <= '0;
            r_sdata_q  <= '0;
            r_target_q <= '0;
            r_zero_q   <= 1'b0;
            r_wreg_q   <= '0;
            r_rw_q     <= 1'b0;
            r_mr_q     <= 1'b0;
            r_mw_q     <= 1'b0;
            r_m2r_q    <= 1'b0;
            r_br_q     <= 1'b0;
        end else begin
            r_valid_q  <= w_valid_d;
            r_result_q <= w_result_d;
            r_sdata_q  <= w_sdata_d;
            r_target_q <= w_target_d;
            r_zero_q   <= w_zero_d;
            r_wreg_q   <= w_wreg_d;
            r_rw_q     <= w_rw_d;
            r_mr_q     <= w_mr_d;
            r_mw_q     <= w_mw_d;
            r_m2r_q    <= w_m2r_d;
            r_br_q     <= w_br_d;
        end
    end

    assign mem_valid         = r_valid_q;
    assign mem_result        = r_result_q;
    assign mem_store_data    = r_sdata_q;
    assign mem_branch_target = r_target_q;
    assign mem_zero          = r_zero_q;
    assign mem_write_reg     = r_wreg_q;
    assign mem_reg_write     = r_rw_q;
    assign mem_mem_read      = r_mr_q;
    assign mem_mem_write     = r_mw_q;
    assign mem_mem_to_reg    = r_m2r_q;
    assign mem_branch        = r_br_q;

    // Decoded strictly from registered state: no ex_* to output path.
    assign pc_src       = r_valid_q & r_br_q & r_zero_q;
    // A load's result is not available until after the Memory stage, so it
    // is flagged as pending rather than forwarded.
    assign fwd_en       = r_valid_q & r_rw_q & ~r_mr_q;
    assign fwd_reg      = r_wreg_q;
    assign fwd_data     = r_result_q;
    assign load_pending = r_valid_q & r_mr_q;

`ifdef EX_MEM_STATS_EN
    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_stall_cnt_q,  w_stall_cnt_d;
    logic [31:0] r_bubble_cnt_q, w_bubble_cnt_d;

    always_comb begin
        w_stall_cnt_d  = r_stall_cnt_q;
        w_bubble_cnt_d = r_bubble_cnt_q;
        if (stall && !flush && (r_stall_cnt_q != C_CNT_MAX)) begin
            w_stall_cnt_d = r_stall_cnt_q + 32'd1;
        end
        // A bubble is any edge that writes valid=0: a flush, or a load of an
        // empty Execute slot. Held (stalled) edges load nothing.
        if ((flush || (!stall && !ex_valid)) && (r_bubble_cnt_q != C_CNT_MAX)) begin
            w_bubble_cnt_d = r_bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt_q  <= '0;
            r_bubble_cnt_q <= '0;
        end else begin
            r_stall_cnt_q  <= w_stall_cnt_d;
            r_bubble_cnt_q <= w_bubble_cnt_d;
        end
    end

    assign stat_stall_cnt  = r_stall_cnt_q;
    assign stat_bubble_cnt = r_bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_reg
//  Purpose  : Self-checking bench for ex_mem_reg. A behavioural model of the
//             pipeline register is compared with the DUT every cycle, and
//             directed scenarios carry hand-computed literal expectations.
//  Options  : EX_MEM_STATS_EN also checks the statistics counters
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, ex_valid, ex_zero;
    logic [31:0] ex_result, ex_store_data, ex_branch_target;
    logic [4:0]  ex_write_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic        mem_valid, mem_zero, mem_reg_write, mem_mem_read, mem_mem_write;
    logic        mem_mem_to_reg, mem_branch, pc_src, fwd_en, load_pending;
    logic [31:0] mem_result, mem_store_data, mem_branch_target, fwd_data;
    logic [4:0]  mem_write_reg, fwd_reg;
`ifdef EX_MEM_STATS_EN
    logic [31:0] stat_stall_cnt, stat_bubble_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_mem_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_zero(ex_zero),
        .ex_store_data(ex_store_data), .ex_branch_target(ex_branch_target),
        .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .mem_valid(mem_valid), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .mem_branch_target(mem_branch_target),
        .mem_zero(mem_zero), .mem_write_reg(mem_write_reg),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_branch(mem_branch), .pc_src(pc_src), .fwd_en(fwd_en),
        .fwd_reg(fwd_reg), .fwd_data(fwd_data), .load_pending(load_pending)
`ifdef EX_MEM_STATS_EN
        , .stat_stall_cnt(stat_stall_cnt), .stat_bubble_cnt(stat_bubble_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit        valid;
        bit [31:0] result, sdata, target;
        bit        zero;
        bit [4:0]  wreg;
        bit        rw, mr, mw, m2r, br;
    } slot_t;

    slot_t       m;
    int unsigned m_stalls, m_bubbles;

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{default: 0};
        return s;
    endfunction

    // What the Memory stage must see for the instruction now in Execute.
    function automatic slot_t from_ex();
        slot_t s;
        bit    live;
        live     = ex_valid;
        s.valid  = ex_valid;
        s.result = ex_result;
        s.sdata  = ex_store_data;
        s.target = ex_branch_target;
        s.zero   = ex_zero;
        s.wreg   = ex_write_reg;
        s.rw     = live && ex_reg_write && (ex_write_reg != 0);
        s.mr     = live && ex_mem_read;
        s.mw     = live && ex_mem_write;
        s.m2r    = live && ex_mem_to_reg;
        s.br     = live && ex_branch;
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m         = empty_slot();
            m_stalls  = 0;
            m_bubbles = 0;
        end else begin
            if (stall && !flush) m_stalls++;
            if (flush) begin
                m = empty_slot();
                m_bubbles++;
            end else if (!stall) begin
                m = from_ex();
                if (!m.valid) m_bubbles++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("valid",   {31'd0, mem_valid},      {31'd0, m.valid});
        chk("result",  mem_result,              m.result);
        chk("sdata",   mem_store_data,          m.sdata);
        chk("target",  mem_branch_target,       m.target);
        chk("zero",    {31'd0, mem_zero},       {31'd0, m.zero});
        chk("wreg",    {27'd0, mem_write_reg},  {27'd0, m.wreg});
        chk("ctl",     {27'd0, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_branch},
                       {27'd0, m.rw, m.mr, m.mw, m.m2r, m.br});
        chk("pc_src",  {31'd0, pc_src},         {31'd0, m.valid & m.br & m.zero});
        chk("fwd_en",  {31'd0, fwd_en},         {31'd0, m.valid & m.rw & ~m.mr});
        chk("fwd_reg", {27'd0, fwd_reg},        {27'd0, m.wreg});
        chk("fwd_data", fwd_data,               m.result);
        chk("load_pend", {31'd0, load_pending}, {31'd0, m.valid & m.mr});
`ifdef EX_MEM_STATS_EN
        chk("stat_stall",  stat_stall_cnt,  m_stalls);
        chk("stat_bubble", stat_bubble_cnt, m_bubbles);
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        stall = 0; flush = 0; ex_valid = 0; ex_zero = 0;
        ex_result = 0; ex_store_data = 0; ex_branch_target = 0; ex_write_reg = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0; ex_branch = 0;
    endtask

    task automatic alu(input logic [31:0] res, input logic [4:0] rd);
        idle_inputs();
        ex_valid = 1; ex_result = res; ex_write_reg = rd; ex_reg_write = 1;
        ex_store_data = res ^ 32'hFFFF_0000;
    endtask

    // Advance past one rising edge; outputs are then stable for checking.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

`ifdef EX_MEM_STATS_EN
    logic [31:0] s_stall0, s_bub0;
`endif

    initial begin
        idle_inputs();
        rst_n = 0;
        #12;
        chk("rst_valid",  {31'd0, mem_valid}, 32'd0);
        chk("rst_result", mem_result, 32'd0);
        rst_n = 1;
        #1;

        // Async reset with an add result of 5 stored.
        alu(32'h0000_0005, 5'd3);
        cyc();
        chk("add_result", mem_result, 32'h5);
        #1 rst_n = 0;
        #1;
        chk("async_rst_result", mem_result, 32'd0);
        chk("async_rst_fwd_en", {31'd0, fwd_en}, 32'd0);
        chk("async_rst_valid",  {31'd0, mem_valid}, 32'd0);
        #1 rst_n = 1;

        // Normal ALU load and forwarding.
        alu(32'h1234_5678, 5'd8);
        cyc();
        chk("load_result", mem_result, 32'h1234_5678);
        chk("load_fwd_en", {31'd0, fwd_en}, 32'd1);
        chk("load_fwd_reg", {27'd0, fwd_reg}, 32'd8);
        chk("load_fwd_data", fwd_data, 32'h1234_5678);

        // Write to $zero is dropped.
        alu(32'hDEAD_BEEF, 5'd0);
        cyc();
        chk("zero_rw", {31'd0, mem_reg_write}, 32'd0);
        chk("zero_fwd_en", {31'd0, fwd_en}, 32'd0);
        chk("zero_data", mem_result, 32'hDEAD_BEEF);

        // Stall holds 0xA for three cycles, then 0xB loads.
        alu(32'hA, 5'd4);
        cyc();
        alu(32'hB, 5'd5);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_hold", mem_result, 32'hA);
        end
        stall = 0;
        cyc();
        chk("stall_release", mem_result, 32'hB);
        chk("stall_release_reg", {27'd0, mem_write_reg}, 32'd5);

        // Taken branch, then flush+stall bubble.
        idle_inputs();
        ex_valid = 1; ex_branch = 1; ex_zero = 1; ex_branch_target = 32'h0040_0020;
        cyc();
        chk("br_pc_src", {31'd0, pc_src}, 32'd1);
        chk("br_target", mem_branch_target, 32'h0040_0020);
`ifdef EX_MEM_STATS_EN
        s_stall0 = stat_stall_cnt;
        s_bub0   = stat_bubble_cnt;
`endif
        flush = 1; stall = 1;
        cyc();
        chk("flush_valid", {31'd0, mem_valid}, 32'd0);
        chk("flush_pc_src", {31'd0, pc_src}, 32'd0);
        chk("flush_target", mem_branch_target, 32'd0);
`ifdef EX_MEM_STATS_EN
        chk("flush_stat_bubble", stat_bubble_cnt, s_bub0 + 32'd1);
        chk("flush_stat_stall",  stat_stall_cnt,  s_stall0);
`endif

        // Load-use: a lw in MEM is pending, not forwarded.
        idle_inputs();
        ex_valid = 1; ex_mem_read = 1; ex_mem_to_reg = 1; ex_reg_write = 1;
        ex_write_reg = 5'd9; ex_result = 32'h1000_0040;
        cyc();
        chk("lu_pending", {31'd0, load_pending}, 32'd1);
        chk("lu_fwd_en", {31'd0, fwd_en}, 32'd0);

        // Invalid slot: controls cleared, data captured as presented.
        idle_inputs();
        ex_valid = 0; ex_branch = 1; ex_zero = 1; ex_reg_write = 1; ex_mem_write = 1;
        ex_write_reg = 5'd7; ex_result = 32'h0000_7777;
        cyc();
        chk("inv_ctl", {27'd0, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_branch}, 32'd0);
        chk("inv_data", mem_result, 32'h7777);
        chk("inv_zero", {31'd0, mem_zero}, 32'd1);
        chk("inv_pc_src", {31'd0, pc_src}, 32'd0);

        // Store instruction carries store data.
        idle_inputs();
        ex_valid = 1; ex_mem_write = 1; ex_store_data = 32'hCAFE_F00D; ex_result = 32'h40;
        cyc();
        chk("sw_sdata", mem_store_data, 32'hCAFE_F00D);
        chk("sw_mw", {31'd0, mem_mem_write}, 32'd1);

        // Reset during stall discards the held instruction.
        alu(32'h5555_AAAA, 5'd12);
        cyc();
        stall = 1;
        cyc();
        #1 rst_n = 0;
        #1;
        chk("rst_stall_result", mem_result, 32'd0);
        chk("rst_stall_valid", {31'd0, mem_valid}, 32'd0);
        cyc();
        chk("rst_held_result", mem_result, 32'd0);
        #1 rst_n = 1;
        stall = 0;
        alu(32'h0BAD_CAFE, 5'd31);
        cyc();
        chk("post_rst_load", mem_result, 32'h0BAD_CAFE);
        chk("post_rst_fwd_en", {31'd0, fwd_en}, 32'd1);

        // A few random-ish vectors through the model-only compare.
        for (int i = 0; i < 40; i++) begin
            ex_valid = 1'($urandom); ex_zero = 1'($urandom);
            ex_result = $urandom; ex_store_data = $urandom; ex_branch_target = $urandom;
            ex_write_reg = 5'($urandom); ex_reg_write = 1'($urandom);
            ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
            ex_mem_to_reg = 1'($urandom); ex_branch = 1'($urandom);
            stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 5) == 0);
            cyc();
        end

        idle_inputs();
        cyc();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
